uart_word_matcher: RTL and testbench
====================================

# uart_word_matcher

Byte-stream pattern matcher that sits between the UART receiver and the 3-second hold counter in the UART word detector. It watches received bytes for a fixed ASCII word. On a match it clears the hold counter, enables it, and ignores further input until the counter reports completion. It then resumes matching from a clean state.

## Interface
Parameters:
- WORD_LEN, 4 — number of characters in the target word, 1..8.
- WORD, "HELO" — target word, 8*WORD_LEN bits. The first character is in the MSB byte (Verilog string-literal order).
- CASE_FOLD, 0 — 1: ASCII letters compare case-insensitively (bit 5 ignored for A-Z/a-z only).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-low reset (0 = reset)
- rx_data  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- hold_done  input  1  completion pulse from the hold counter (its counter_done)
- timer_clr  output  1  one-cycle synchronous clear to the hold counter's rst
- timer_en  output  1  enable to the hold counter's en; level
- match_pulse  output  1  one-cycle pulse per detected word
- busy  output  1  high while in CLR or HOLD
- match_count  output  8  number of detections, wraps 255→0

## Operation
- States:
  - IDLE: index=0.
  - MATCH: 0<index<WORD_LEN.
  - CLR
  - HOLD
- Character i of the word: WORD[8*(WORD_LEN-1-i) +: 8].
- IDLE/MATCH, on rx_valid:
  - Byte equals char[index] and index=WORD_LEN-1 → go to CLR, index<=0.
  - Byte equals char[index] otherwise → index<=index+1.
  - Byte differs from char[index] → index<=1 if the byte equals char[0], else index<=0. This is a simple restart, not full KMP. Self-overlapping words such as "AAB" on "AAAB" are missed by design.
- IDLE/MATCH, no rx_valid: index holds. There is no inter-byte timeout.
- CLR: lasts exactly one cycle, then goes to HOLD.
- HOLD: stays until hold_done=1 is sampled, then goes to IDLE.
- rx_valid in CLR or HOLD: byte discarded, index unaffected (remains 0).
- hold_done outside HOLD: ignored.
- WORD_LEN=1: every matching byte goes IDLE→CLR directly.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Timing
- Reset values (rst=0, immediate):
  - state=IDLE, index=0.
  - timer_clr=0, timer_en=0, match_pulse=0, busy=0, match_count=0.
- Last matching byte sampled at edge N:
  - Cycle N+1: timer_clr=1, match_pulse=1, busy=1, timer_en=0, match_count incremented.
  - Cycle N+2 onward: timer_clr=0, match_pulse=0, timer_en=1.
- hold_done=1 sampled at edge M (in HOLD):
  - Cycle M+1: timer_en=0, busy=0, state IDLE.
  - A byte strobed in cycle M+1 is matched normally.
- rx_valid and hold_done in the same HOLD cycle: byte discarded, exit taken.
- Reset mid-HOLD: timer_en drops immediately. The counter is re-cleared by timer_clr on the next match.
- Latency, final byte to timer_en: 2 cycles.
- Minimum byte spacing: 1 cycle. Back-to-back strobes are supported.

## Structure
- Shared package/header uart_word_pkg: state encoding constants (IDLE/MATCH/CLR/HOLD, 2 bits) and the default word constant.
- One natural sub-module: char_cmp, a combinational byte comparator with CASE_FOLD. It is instantiated twice: vs char[index] and vs char[0].
- Index width: $clog2(WORD_LEN)+1. Index is compared against WORD_LEN-1 at full width.
- Top level wires timer_clr/timer_en to counter_3s rst/en, and hold_done to counter_done.

## Test plan
- **Basic match:** reset, then bytes "H","E","L","O" one per 10 cycles → match_pulse and timer_clr high one cycle after "O". timer_en high from the following cycle. match_count=1.
- **Restart on mismatch:** "H","E","H","E","L","O" → exactly one match_pulse, after the final "O". "HXLO" → no pulse, index=0 after "X".
- **Input ignored while busy:** match "HELO", then "HELO" again during HOLD, then hold_done pulse → no second match_pulse, timer_en drops one cycle after hold_done, match_count=1.
- **Simultaneous events:** rx_valid "H" in the same cycle as hold_done → byte discarded. "ELO" afterwards → no match.
- **Case fold:** CASE_FOLD=1 with "hElo" → match. CASE_FOLD=0 with "hElo" → no match. With CASE_FOLD=1, "@" vs "`" are unequal.
- **Async reset:** assert rst low asynchronously mid-HOLD → timer_en=0 and busy=0 before the next clk edge, match_count=0. Then 256 matches → match_count=0 (wrap).

Source files
------------

// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word matcher: FSM state encoding, default target word
// and an ASCII letter test used by the byte comparator.
package uart_word_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MATCH = 2'd1,
      ST_CLR   = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_WORD = "HELO";

   function automatic logic is_alpha(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
   endfunction

endpackage

// File: rtl/uart_word_matcher_char_cmp.sv
// Combinational byte comparator; with CASE_FOLD set, ASCII letters compare
// case-insensitively and every other byte value compares exactly.
module char_cmp
   import uart_word_pkg::*;
#(
   parameter bit CASE_FOLD = 1'b0
) (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic       o_eq
);

   function automatic logic [7:0] fold(input logic [7:0] c);
      if (CASE_FOLD && is_alpha(c)) return c & 8'hDF;
      return c;
   endfunction

   assign o_eq = (fold(i_a) == fold(i_b));

endmodule

// File: rtl/uart_word_matcher.sv
// Watches a received byte stream for a fixed word, then clears/enables the hold
// counter and ignores input until the counter reports completion.
module uart_word_matcher
   import uart_word_pkg::*;
#(
   parameter int unsigned              WORD_LEN  = 4,
   parameter logic [8*WORD_LEN-1:0]    WORD      = DEFAULT_WORD,
   parameter bit                       CASE_FOLD = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       hold_done,
   output logic       timer_clr,
   output logic       timer_en,
   output logic       match_pulse,
   output logic       busy,
   output logic [7:0] match_count
);

   localparam int unsigned    IW       = $clog2(WORD_LEN) + 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(WORD_LEN - 1);

   state_t        r_state;
   logic [IW-1:0] r_index;
   logic          r_timer_clr;
   logic          r_timer_en;
   logic          r_match_pulse;
   logic          r_busy;
   logic [7:0]    r_match_count;

   logic [7:0]    w_char_cur;
   logic [7:0]    w_char_first;
   logic          w_eq_cur;
   logic          w_eq_first;

   always_comb begin
      w_char_cur = '0;
      for (int unsigned i = 0; i < WORD_LEN; i++) begin
         if (r_index == IW'(i)) w_char_cur = WORD[8*(WORD_LEN-1-i) +: 8];
      end
   end

   assign w_char_first = WORD[8*WORD_LEN-1 -: 8];

   char_cmp #(.CASE_FOLD(CASE_FOLD)) u_cmp_cur (
      .i_a  (rx_data),
      .i_b  (w_char_cur),
      .o_eq (w_eq_cur)
   );

   char_cmp #(.CASE_FOLD(CASE_FOLD)) u_cmp_first (
      .i_a  (rx_data),
      .i_b  (w_char_first),
      .o_eq (w_eq_first)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_index       <= '0;
         r_timer_clr   <= 1'b0;
         r_timer_en    <= 1'b0;
         r_match_pulse <= 1'b0;
         r_busy        <= 1'b0;
         r_match_count <= '0;
      end else begin
         r_timer_clr   <= 1'b0;
         r_match_pulse <= 1'b0;
         case (r_state)
            ST_IDLE, ST_MATCH: begin
               if (rx_valid) begin
                  if (w_eq_cur) begin
                     if (r_index == LAST_IDX) begin
                        r_state       <= ST_CLR;
                        r_index       <= '0;
                        r_timer_clr   <= 1'b1;
                        r_match_pulse <= 1'b1;
                        r_busy        <= 1'b1;
                        r_match_count <= r_match_count + 8'd1;
                     end else begin
                        r_state <= ST_MATCH;
                        r_index <= r_index + IW'(1);
                     end
                  end else if (w_eq_first) begin
                     // simple restart: a mismatching byte may itself begin a new word
                     r_state <= ST_MATCH;
                     r_index <= IW'(1);
                  end else begin
                     r_state <= ST_IDLE;
                     r_index <= '0;
                  end
               end
            end
            ST_CLR: begin
               r_state    <= ST_HOLD;
               r_timer_en <= 1'b1;
            end
            ST_HOLD: begin
               if (hold_done) begin
                  r_state    <= ST_IDLE;
                  r_timer_en <= 1'b0;
                  r_busy     <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign timer_clr   = r_timer_clr;
   assign timer_en    = r_timer_en;
   assign match_pulse = r_match_pulse;
   assign busy        = r_busy;
   assign match_count = r_match_count;

endmodule

// File: tb/tb_uart_word_matcher.sv
// Randomized bench for uart_word_matcher: three instances (exact "HELO", folded "HELO",
// folded one-character "@") checked every cycle against a per-byte reference model.
module tb_uart_word_matcher;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       hold_done;

  logic [2:0] w_clr, w_en, w_pulse, w_busy;
  logic [7:0] w_cnt [3];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, one entry per instance
  logic [7:0] m_word  [3][4];
  int         m_len   [3];
  bit         m_fold  [3];
  int         m_prog  [3];
  int         m_phase [3];   // 0 matching, 1 clear cycle, 2 holding
  logic [7:0] m_cnt   [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_word_matcher #(.WORD_LEN(4), .WORD(32'h48454C4F), .CASE_FOLD(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .hold_done(hold_done),
    .timer_clr(w_clr[0]), .timer_en(w_en[0]), .match_pulse(w_pulse[0]),
    .busy(w_busy[0]), .match_count(w_cnt[0])
  );

  uart_word_matcher #(.WORD_LEN(4), .WORD(32'h48454C4F), .CASE_FOLD(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .hold_done(hold_done),
    .timer_clr(w_clr[1]), .timer_en(w_en[1]), .match_pulse(w_pulse[1]),
    .busy(w_busy[1]), .match_count(w_cnt[1])
  );

  uart_word_matcher #(.WORD_LEN(1), .WORD(8'h40), .CASE_FOLD(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .hold_done(hold_done),
    .timer_clr(w_clr[2]), .timer_en(w_en[2]), .match_pulse(w_pulse[2]),
    .busy(w_busy[2]), .match_count(w_cnt[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] observed(input int k);
    return {20'd0, w_cnt[k], w_busy[k], w_en[k], w_pulse[k], w_clr[k]};
  endfunction

  function automatic logic [31:0] expected(input int k);
    logic in_clr;
    in_clr = (m_phase[k] == 1);
    return {20'd0, m_cnt[k], m_phase[k] != 0, m_phase[k] == 2, in_clr, in_clr};
  endfunction

  function automatic bit same_char(input int k, input logic [7:0] a, input logic [7:0] b);
    bit a_letter, b_letter;
    a_letter = ((a >= "A") && (a <= "Z")) || ((a >= "a") && (a <= "z"));
    b_letter = ((b >= "A") && (b <= "Z")) || ((b >= "a") && (b <= "z"));
    if (m_fold[k] && a_letter && b_letter) return (a | 8'h20) == (b | 8'h20);
    return a == b;
  endfunction

  task automatic model_reset();
    for (int unsigned k = 0; k < 3; k++) begin
      m_prog[k]  = 0;
      m_phase[k] = 0;
      m_cnt[k]   = 8'd0;
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic [7:0] d, input logic hd);
    if (m_phase[k] == 1) m_phase[k] = 2;
    else if (m_phase[k] == 2) begin
      if (hd) m_phase[k] = 0;
    end else if (v) begin
      if (same_char(k, d, m_word[k][m_prog[k]])) begin
        m_prog[k]++;
        if (m_prog[k] == m_len[k]) begin
          m_prog[k]  = 0;
          m_phase[k] = 1;
          m_cnt[k]   = m_cnt[k] + 8'd1;
        end
      end else begin
        m_prog[k] = same_char(k, d, m_word[k][0]) ? 1 : 0;
      end
    end
  endtask

  // entered and left at a falling edge; outputs are compared after every rising edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic hd);
    rx_valid  = v;
    rx_data   = d;
    hold_done = hd;
    @(posedge clk);
    for (int unsigned k = 0; k < 3; k++) model_step(k, v, d, hd);
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) check($sformatf("outs_dut%0d", k), observed(k), expected(k));
  endtask

  task automatic send_str(input logic [63:0] s, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, s[8*(n-1-i) +: 8], 1'b0);
      repeat (gap) cycle(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic release_hold();
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  logic [7:0] alphabet [12];

  initial begin
    alphabet = '{"H", "E", "L", "O", "h", "e", "l", "o", "@", 8'h60, "X", "E"};
    m_word[0] = '{"H", "E", "L", "O"};
    m_word[1] = '{"H", "E", "L", "O"};
    m_word[2] = '{"@", 8'h00, 8'h00, 8'h00};
    m_len  = '{4, 4, 1};
    m_fold = '{1'b0, 1'b1, 1'b1};
    model_reset();

    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; hold_done = 1'b0;
    repeat (2) @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) check($sformatf("reset_dut%0d", k), observed(k), 32'd0);
    rst = 1'b1;

    send_str("HELO", 4, 9);
    check("basic_cnt", {24'd0, w_cnt[0]}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    send_str("HEHELO", 6, 0);
    check("restart_cnt", {24'd0, w_cnt[0]}, 32'd2);
    release_hold();
    send_str("HXLO", 4, 0);
    check("nomatch_cnt", {24'd0, w_cnt[0]}, 32'd2);

    send_str("HELO", 4, 0);
    cycle(1'b0, 8'h00, 1'b0);
    send_str("HELO", 4, 0);
    cycle(1'b0, 8'h00, 1'b1);
    check("busy_en_drop", {31'd0, w_en[0]}, 32'd0);
    check("busy_cnt", {24'd0, w_cnt[0]}, 32'd3);

    send_str("HELO", 4, 0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, "H", 1'b1);
    send_str("ELO", 3, 1);
    check("simul_cnt", {24'd0, w_cnt[0]}, 32'd4);

    send_str("hElo", 4, 0);
    check("fold0_cnt", {24'd0, w_cnt[0]}, 32'd4);
    check("fold1_cnt", {24'd0, w_cnt[1]}, 32'd5);
    release_hold();

    send_str(24'h604060, 3, 1);
    check("one_char_cnt", {24'd0, w_cnt[2]}, 32'd1);
    release_hold();

    for (int unsigned n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 1) == 1), alphabet[$urandom_range(0, 11)],
            ($urandom_range(0, 5) == 0));
    end

    // reach HOLD, then reset asynchronously between clock edges
    release_hold();
    send_str("HELO", 4, 0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("pre_reset_en", {31'd0, w_en[0]}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("areset_dut0", observed(0), 32'd0);
    check("areset_dut1", observed(1), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int unsigned n = 0; n < 256; n++) begin
      send_str("HELO", 4, 0);
      release_hold();
    end
    check("wrap_cnt0", {24'd0, w_cnt[0]}, 32'd0);
    check("wrap_cnt1", {24'd0, w_cnt[1]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
